dr_byte_loader: RTL and testbench

Sequencer that fills the 32-bit byte-loaded data register from a byte-wide memory port. On a single start command it issues 1, 2 or 4 consecutive byte reads and drives the data register's enable and function-select so the assembled value lands right-justified, zero- or sign-extended, in big-endian byte order. It sits between the control unit, which issues load commands, and the memory / data-register pair. It owns the memory read handshake, address increment and timeout.

---
 rtl/dr_byte_loader.sv | 156 +++++++++++++++
 tb/tb_dr_byte_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_byte_loader.sv
// dr_byte_loader
// ----------------------------------------------------------------------------
// Fills a 32-bit byte-loaded data register from a byte-wide memory port.
// A single Start command issues 1, 2 or 4 consecutive byte reads. The first
// byte is loaded sign- or zero-extended, and each later byte shifts the
// register left by 8 and enters at [7:0]. The result is the big-endian value,
// right-justified and extended.
//
// Ports
//   Clock      in   system clock, all state on the rising edge
//   Reset      in   synchronous, active-high reset
//   Start      in   load command, sampled only while idle
//   Address    in   byte address of the first (most significant) byte
//   Size       in   00 byte, 01 halfword, 10 word, 11 reserved (error)
//   Signed     in   1 = sign-extend, 0 = zero-extend
//   MemRead    out  byte read request (registered)
//   MemAddr    out  current byte address (registered)
//   MemValid   in   memory byte valid this cycle
//   DR_E       out  data register enable (combinational, Mealy)
//   DR_FunSel  out  data register function select (combinational, Mealy)
//   Busy       out  high while reads are outstanding (registered)
//   Done       out  one-cycle pulse, load complete (registered)
//   Error      out  one-cycle pulse, reserved Size or timeout (registered)
// ----------------------------------------------------------------------------
module dr_byte_loader #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] Address,
    input  logic [1:0]    Size,
    input  logic          Signed,
    output logic          MemRead,
    output logic [AW-1:0] MemAddr,
    input  logic          MemValid,
    output logic          DR_E,
    output logic [1:0]    DR_FunSel,
    output logic          Busy,
    output logic          Done,
    output logic          Error
);

    // Wait counter only needs to hold 0 .. TIMEOUT-1.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr;
    logic [1:0]      size_q;
    logic            signed_q;
    logic [1:0]      idx;
    logic [WW-1:0]   wait_cnt;
    logic [1:0]      last_idx;
    logic            accept;

    assign MemAddr = addr;

    // Index of the final byte for the latched size (reserved never reaches READ).
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first,
        // so no path through the block can leave it unassigned and infer a latch.
        last_idx = 2'd0;
        case (size_q)
            2'b01:   last_idx = 2'd1;
            2'b10:   last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    end

    // NOTE: the byte strobe is gated by Reset so a byte arriving in the reset
    // cycle never reaches the data register, even though the state register
    // only clears at the next edge.
    assign accept = (state == READ) && MemValid && !Reset;

    always_comb begin
        DR_E      = accept;
        DR_FunSel = 2'b00;
        if (accept) begin
            if (idx == 2'd0) DR_FunSel = signed_q ? 2'b00 : 2'b01;
            else             DR_FunSel = 2'b10;
        end
    end

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            addr     <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            idx      <= 2'd0;
            wait_cnt <= '0;
            MemRead  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        addr     <= Address;
                        size_q   <= Size;
                        signed_q <= Signed;
                        idx      <= 2'd0;
                        wait_cnt <= '0;
                        if (Size == 2'b11) begin
                            state <= ERR;
                            Error <= 1'b1;
                        end else begin
                            state   <= READ;
                            MemRead <= 1'b1;
                            Busy    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (MemValid) begin
                        addr     <= addr + AW'(1);
                        idx      <= idx + 2'd1;
                        wait_cnt <= '0;
                        if (idx == last_idx) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            MemRead <= 1'b0;
                            Busy    <= 1'b0;
                        end
                    end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th consecutive empty cycle: abort.
                        state    <= ERR;
                        Error    <= 1'b1;
                        MemRead  <= 1'b0;
                        Busy     <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dr_byte_loader.sv
// tb_dr_byte_loader
// ----------------------------------------------------------------------------
// Self-checking bench for dr_byte_loader. A reactive memory answers reads with
// a per-byte wait plan, a data-register model absorbs DR_E/DR_FunSel, and a
// scoreboard holds the expected outcome of each load (computed from byte
// values with plain arithmetic). A monitor pops and compares on every
// Done/Error pulse.
// ----------------------------------------------------------------------------
module tb_dr_byte_loader;

    localparam int AW      = 16;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [AW-1:0] Address;
    logic [1:0]    Size;
    logic          Signed;
    logic          MemRead;
    logic [AW-1:0] MemAddr;
    logic          MemValid;
    logic          DR_E;
    logic [1:0]    DR_FunSel;
    logic          Busy;
    logic          Done;
    logic          Error;

    dr_byte_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Address  (Address),
        .Size     (Size),
        .Signed   (Signed),
        .MemRead  (MemRead),
        .MemAddr  (MemAddr),
        .MemValid (MemValid),
        .DR_E     (DR_E),
        .DR_FunSel(DR_FunSel),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory image and reactive responder
    // ------------------------------------------------------------------
    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] mem_data;
    int         plan [4];
    int         byte_k;
    int         wait_left;

    always @(posedge Clock) begin
        #1;
        if (MemRead === 1'b1) begin
            if (wait_left > 0) begin
                MemValid  = 1'b0;
                mem_data  = 8'($urandom);
                wait_left--;
            end else begin
                MemValid  = 1'b1;
                mem_data  = mem[MemAddr];
                byte_k++;
                wait_left = (byte_k < 4) ? plan[byte_k] : 0;
            end
        end else begin
            // Stray strobes outside a read must be ignored by the DUT.
            MemValid = 1'($urandom);
            mem_data = 8'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard entry and reference model
    // ------------------------------------------------------------------
    typedef struct {
        int          start_cyc;
        logic [1:0]  kind;      // {Done, Error}
        int          lat;
        logic [31:0] dr;
        int          n_dre;
        logic [7:0]  fs;
        logic [63:0] addrs;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] exp_dr = 32'h0;

    // Value of the first k bytes at a, big-endian, extended to 32 bits.
    function automatic logic [31:0] ext_value(input logic [AW-1:0] a, input int k, input logic sg);
        longint v = 0;
        for (int i = 0; i < k; i++) v = v * 256 + longint'(mem[AW'(a + i)]);
        if (sg && mem[a][7]) v = v - (longint'(1) << (8 * k));
        return v[31:0];
    endfunction

    task automatic issue_load(input logic [AW-1:0] a, input logic [1:0] sz, input logic sg,
                              input int w0, input int w1, input int w2, input int w3);
        exp_t e;
        int   n;
        int   k;
        bit   abort;
        @(posedge Clock); #1;
        plan = '{w0, w1, w2, w3};
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        e.start_cyc = cyc;
        e.fs    = 8'h0;
        e.addrs = 64'h0;
        e.lat   = 1;
        k       = 0;
        abort   = 1'b0;
        if (n == 0) begin
            e.kind = 2'b01;
        end else begin
            for (int i = 0; i < n && !abort; i++) begin
                if (plan[i] >= TIMEOUT) begin
                    e.lat += TIMEOUT;
                    abort = 1'b1;
                end else begin
                    e.lat  += plan[i] + 1;
                    e.fs    = {e.fs[5:0], (i == 0) ? (sg ? 2'b00 : 2'b01) : 2'b10};
                    e.addrs = {e.addrs[47:0], 16'(AW'(a + i))};
                    k++;
                end
            end
            e.kind = abort ? 2'b01 : 2'b10;
        end
        if (k > 0) exp_dr = ext_value(a, k, sg);
        e.dr    = exp_dr;
        e.n_dre = k;
        exp_q.push_back(e);
        byte_k    = 0;
        wait_left = plan[0];
        Start = 1'b1; Address = a; Size = sz; Signed = sg;
        // Junk commands while busy and in the Done/Error cycle must be ignored.
        repeat (e.lat) begin
            @(posedge Clock); #1;
            Start   = 1'($urandom);
            Address = AW'($urandom);
            Size    = 2'($urandom);
            Signed  = 1'($urandom);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: data-register model + compare on Done/Error
    // ------------------------------------------------------------------
    logic [31:0] dr_model = 32'h0;
    int          obs_dre, obs_busy, obs_mrd;
    logic [7:0]  obs_fs;
    logic [63:0] obs_addrs;

    always @(negedge Clock) begin
        if (DR_E === 1'b1) begin
            case (DR_FunSel)
                2'b00:   dr_model = {{24{mem_data[7]}}, mem_data};
                2'b01:   dr_model = {24'h0, mem_data};
                2'b10:   dr_model = {dr_model[23:0], mem_data};
                default: dr_model = dr_model;
            endcase
        end
        if (Reset) begin
            obs_dre = 0; obs_busy = 0; obs_mrd = 0; obs_fs = 8'h0; obs_addrs = 64'h0;
        end else begin
            if (Busy === 1'b1)    obs_busy++;
            if (MemRead === 1'b1) obs_mrd++;
            if (DR_E === 1'b1) begin
                obs_dre++;
                obs_fs    = {obs_fs[5:0], DR_FunSel};
                obs_addrs = {obs_addrs[47:0], 16'(MemAddr)};
            end
            if (Done === 1'b1 || Error === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_end_pulse", {62'h0, Done, Error}, 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("end_kind",     {62'h0, Done, Error}, {62'h0, e.kind});
                    check("end_latency",  64'(cyc - e.start_cyc), 64'(e.lat));
                    check("dr_value",     64'(dr_model), 64'(e.dr));
                    check("dr_e_count",   64'(obs_dre), 64'(e.n_dre));
                    check("funsel_seq",   64'(obs_fs), 64'(e.fs));
                    check("addr_seq",     obs_addrs, e.addrs);
                    check("busy_cycles",  64'(obs_busy), 64'(e.lat - 1));
                    check("memread_cycles", 64'(obs_mrd), 64'(e.lat - 1));
                end
                obs_dre = 0; obs_busy = 0; obs_mrd = 0; obs_fs = 8'h0; obs_addrs = 64'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        Reset = 1'b1; Start = 1'b0; Address = '0; Size = 2'b00; Signed = 1'b0;
        MemValid = 1'b0; mem_data = 8'h0;
        plan = '{0, 0, 0, 0}; byte_k = 0; wait_left = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_outputs", {45'h0, MemRead, MemAddr, DR_E, DR_FunSel, Busy, Done, Error}, 64'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Word, zero waits.
        mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56; mem[16'h0103] = 8'h78;
        issue_load(16'h0100, 2'b10, 1'b0, 0, 0, 0, 0);
        // Signed halfword, one wait before the second byte.
        mem[16'h0200] = 8'h9A; mem[16'h0201] = 8'hBC;
        issue_load(16'h0200, 2'b01, 1'b1, 0, 1, 0, 0);
        // Byte 0x80 signed and unsigned.
        mem[16'h0300] = 8'h80;
        issue_load(16'h0300, 2'b00, 1'b1, 0, 0, 0, 0);
        issue_load(16'h0300, 2'b00, 1'b0, 0, 0, 0, 0);
        // Word whose second byte never arrives.
        issue_load(16'h0400, 2'b10, 1'b0, 0, NEVER, 0, 0);
        // Reserved size.
        issue_load(16'h0500, 2'b11, 1'b0, 0, 0, 0, 0);
        // Longest legal waits complete; exactly TIMEOUT waits abort.
        issue_load(16'h0600, 2'b10, 1'b1, TIMEOUT - 1, 0, TIMEOUT - 1, 0);
        issue_load(16'h0700, 2'b01, 1'b0, TIMEOUT, 0, 0, 0);

        // Reset during the third byte's wait of a word load.
        @(posedge Clock); #1;
        plan = '{0, 0, NEVER, 0}; byte_k = 0; wait_left = 0;
        Start = 1'b1; Address = 16'h0A00; Size = 2'b10; Signed = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_mid_load_outputs", {45'h0, MemRead, MemAddr, DR_E, DR_FunSel, Busy, Done, Error}, 64'h0);
        check("reset_mid_load_dr", 64'(dr_model), 64'(ext_value(16'h0A00, 2, 1'b1)));
        exp_dr = ext_value(16'h0A00, 2, 1'b1);

        // Reset coinciding with an arriving byte: no register write.
        @(posedge Clock); #1;
        plan = '{0, 0, 0, 0}; byte_k = 0; wait_left = 0;
        Start = 1'b1; Address = 16'h0B00; Size = 2'b00; Signed = 1'b0;
        @(posedge Clock); #1;
        Start = 1'b0; Reset = 1'b1;
        @(negedge Clock);
        check("reset_gates_dr_e", {63'h0, DR_E}, 64'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_accept_outputs", {45'h0, MemRead, MemAddr, DR_E, DR_FunSel, Busy, Done, Error}, 64'h0);

        // Fresh byte load, then address wrap.
        issue_load(16'h0800, 2'b00, 1'b0, 0, 0, 0, 0);
        mem[16'hFFFE] = 8'hDE; mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'hBE; mem[16'h0001] = 8'hEF;
        issue_load(16'hFFFE, 2'b10, 1'b0, 0, 0, 0, 0);

        // Randomized loads.
        for (int t = 0; t < 60; t++) begin
            int w [4];
            int r;
            logic [1:0] sz;
            for (int i = 0; i < 4; i++) begin
                r = $urandom_range(0, 19);
                if (r < 12)       w[i] = 0;
                else if (r < 17)  w[i] = $urandom_range(1, 3);
                else if (r == 17) w[i] = TIMEOUT - 1;
                else if (r == 18) w[i] = TIMEOUT;
                else              w[i] = NEVER;
            end
            r  = $urandom_range(0, 9);
            sz = (r == 9) ? 2'b11 : 2'(r % 3);
            if ($urandom_range(0, 3) == 0) begin
                Start = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge Clock);
            end
            issue_load(AW'($urandom), sz, 1'($urandom), w[0], w[1], w[2], w[3]);
        end

        Start = 1'b0;
        repeat (30) @(posedge Clock);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
